pc_gen: RTL



---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_ras.sv | 50 +++++
 rtl/pc_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants and next-PC source encoding for the fetch-stage PC generator.
package pc_pkg;

  localparam int          PC_WIDTH     = 32;
  localparam logic [31:0] PC_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;
  localparam int          PC_INC       = 4;
  localparam int          PC_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SRC_SEQ   = 3'd0,
    SRC_REDIR = 3'd1,
    SRC_PEND  = 3'd2,
    SRC_RAS   = 3'd3,
    SRC_EXC   = 3'd4,
    SRC_ERET  = 3'd5
  } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] top_idx_s;

  assign top_idx_s = ptr_r - PTR_ONE;
  assign top       = mem_r[top_idx_s];
  assign empty     = (cnt_r == {CNT_W{1'b0}});
  assign full      = (cnt_r == CNT_FULL);

  // Stack storage, write pointer and occupancy; push+pop replaces the top in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= {PTR_W{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push && pop && !empty) begin
      mem_r[top_idx_s] <= push_data;
    end else if (push) begin
      mem_r[ptr_r] <= push_data;
      ptr_r        <= ptr_r + PTR_ONE;
      if (!full) cnt_r <= cnt_r + CNT_ONE;
    end else if (pop && !empty) begin
      ptr_r <= ptr_r - PTR_ONE;
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator with stall-buffered redirect and EPC.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC  = WIDTH'(PC_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
  parameter int               INC       = PC_INC,
  parameter int               RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret_req,
  input  logic             call_push,
  input  logic             ret_pop,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] EPC,
  output logic             redirect_pending,
  output logic             pc_misaligned,
  output logic             ras_empty
);

  logic [WIDTH-1:0] pc_r, epc_r, pend_target_r;
  logic             pend_r;
  logic [WIDTH-1:0] pc_next_s, epc_next_s, pend_target_next_s, pc_inc_s;
  logic             pend_next_s, advance_s, ras_pop_req_s;
  logic [WIDTH-1:0] ras_top_s;
  logic             ras_empty_s;
  pc_src_e          src_s;

  assign pc_inc_s  = pc_r + WIDTH'(INC);
  assign advance_s = exc_req | eret_req | enable;

`ifdef PC_RAS_EN
  logic ras_push_s, ras_pop_s, ras_full_unused_s;

  // Exceptions and returns from exception leave the stack untouched.
  assign ras_push_s    = enable & call_push & ~exc_req & ~eret_req;
  assign ras_pop_req_s = enable & ret_pop & ~ras_empty_s;
  assign ras_pop_s     = (src_s == SRC_RAS);

  pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_data (pc_inc_s),
    .top       (ras_top_s),
    .empty     (ras_empty_s),
    .full      (ras_full_unused_s)
  );
`else
  logic unused_ras_s;

  assign unused_ras_s  = call_push ^ ret_pop;
  assign ras_pop_req_s = 1'b0;
  assign ras_top_s     = {WIDTH{1'b0}};
  assign ras_empty_s   = 1'b1;
`endif

  // Fixed-priority source selection for the next PC.
  always_comb begin
    src_s = SRC_SEQ;
    if (exc_req)             src_s = SRC_EXC;
    else if (eret_req)       src_s = SRC_ERET;
    else if (redirect_valid) src_s = SRC_REDIR;
    else if (pend_r)         src_s = SRC_PEND;
    else if (ras_pop_req_s)  src_s = SRC_RAS;
    else                     src_s = SRC_SEQ;
  end

  // Next-state values for PC, EPC and the stall redirect buffer.
  always_comb begin
    pc_next_s          = pc_r;
    epc_next_s         = epc_r;
    pend_next_s        = pend_r;
    pend_target_next_s = pend_target_r;
    if (advance_s) begin
      case (src_s)
        SRC_EXC:   pc_next_s = EXC_VEC;
        SRC_ERET:  pc_next_s = epc_r;
        SRC_REDIR: pc_next_s = redirect_target;
        SRC_PEND:  pc_next_s = pend_target_r;
        SRC_RAS:   pc_next_s = ras_top_s;
        SRC_SEQ:   pc_next_s = pc_inc_s;
        default:   pc_next_s = pc_r;
      endcase
    end else begin
      pc_next_s = pc_r;
    end
    if (exc_req) epc_next_s = exc_pc;
    else         epc_next_s = epc_r;
    // Any taken advance consumes the buffer; only a stalled redirect fills it.
    if (advance_s) begin
      pend_next_s        = 1'b0;
      pend_target_next_s = {WIDTH{1'b0}};
    end else if (redirect_valid) begin
      pend_next_s        = 1'b1;
      pend_target_next_s = redirect_target;
    end else begin
      pend_next_s        = pend_r;
      pend_target_next_s = pend_target_r;
    end
  end

  // Architectural PC state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r          <= RESET_PC;
      epc_r         <= {WIDTH{1'b0}};
      pend_r        <= 1'b0;
      pend_target_r <= {WIDTH{1'b0}};
    end else begin
      pc_r          <= pc_next_s;
      epc_r         <= epc_next_s;
      pend_r        <= pend_next_s;
      pend_target_r <= pend_target_next_s;
    end
  end

  assign PC               = pc_r;
  assign EPC              = epc_r;
  assign redirect_pending = pend_r;
  assign pc_misaligned    = |pc_r[1:0];
  assign ras_empty        = ras_empty_s;

endmodule
